// File: rtl/piso_shift_tx.sv
// ============================================================================
//  Module      : piso_shift_tx
//  Description : Parallel-in/serial-out shift transmitter. Accepts a WIDTH-bit
//                word on a single-cycle load handshake and shifts it out one
//                bit at a time, each bit held for CLKS_PER_BIT clocks, with a
//                valid strobe per bit and a done pulse at end of word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             pause,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_IDX_W = $clog2(WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shreg_shifted;
    logic               w_bit_end;

    // Output end of the register and the one-step shift toward it depend on
    // the transmit order.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_out_bit       = r_shreg[0];
            assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_out_bit       = r_shreg[WIDTH-1];
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    // A bit period ends on a non-paused SHIFT clock with the counter at its top.
    assign w_bit_end = (r_state == S_SHIFT) && !pause && (r_cnt == c_CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bit_end && (r_idx == c_IDX_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, then count bit periods and shift; pause
    // freezes everything so sout holds its current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shreg <= din;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!pause) begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_idx   <= r_idx + c_IDX_ONE;
                            r_shreg <= w_shreg_shifted;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register.
    assign ready      = (r_state == S_IDLE);
    assign busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign sout_valid = (r_state == S_SHIFT);
    assign done       = (r_state == S_DONE);
    assign sout       = (r_state == S_SHIFT) && w_out_bit;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
// ============================================================================
//  Module      : tb_piso_shift_tx
//  Description : Directed self-checking bench for piso_shift_tx. Three
//                instances (LSB-first C=4, MSB-first C=4, LSB-first C=1)
//                share the inputs; one is observed at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_shift_tx;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       pause;

    logic a_ready, a_busy, a_sout, a_valid, a_done;
    logic b_ready, b_busy, b_sout, b_valid, b_done;
    logic c_ready, c_busy, c_sout, c_valid, c_done;

    logic o_ready, o_busy, o_sout, o_valid, o_done;
    int   sel;

    int n_total;
    int n_bad;

    piso_shift_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .din(din), .pause(pause),
        .ready(a_ready), .busy(a_busy), .sout(a_sout),
        .sout_valid(a_valid), .done(a_done)
    );

    piso_shift_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst(rst), .load(load), .din(din), .pause(pause),
        .ready(b_ready), .busy(b_busy), .sout(b_sout),
        .sout_valid(b_valid), .done(b_done)
    );

    piso_shift_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u_dut_c (
        .clk(clk), .rst(rst), .load(load), .din(din), .pause(pause),
        .ready(c_ready), .busy(c_busy), .sout(c_sout),
        .sout_valid(c_valid), .done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance to the observation signals.
    always_comb begin
        o_ready = a_ready;
        o_busy  = a_busy;
        o_sout  = a_sout;
        o_valid = a_valid;
        o_done  = a_done;
        case (sel)
            1: begin
                o_ready = b_ready; o_busy = b_busy; o_sout = b_sout;
                o_valid = b_valid; o_done = b_done;
            end
            2: begin
                o_ready = c_ready; o_busy = c_busy; o_sout = c_sout;
                o_valid = c_valid; o_done = c_done;
            end
            default: begin
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        load = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load a word, then follow it cycle by cycle against the expected bit
    // schedule. pbit/plen insert a pause inside one bit; disturb toggles
    // load and changes din during bit 2.
    task automatic send_word(input string tag, input logic [7:0] word, input int c,
                             input bit lsb, input int pbit, input int plen, input bit disturb);
        logic exp_b;
        int   dur;
        din  = word;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_b = lsb ? word[k] : word[7-k];
            dur   = c + ((k == pbit) ? plen : 0);
            for (int j = 0; j < dur; j++) begin
                check_eq($sformatf("%s b%0d c%0d sout", tag, k, j), {31'd0, o_sout}, {31'd0, exp_b});
                check_eq($sformatf("%s b%0d c%0d valid", tag, k, j), {31'd0, o_valid}, 32'd1);
                check_eq($sformatf("%s b%0d c%0d done", tag, k, j), {31'd0, o_done}, 32'd0);
                pause = (k == pbit) && (j >= 1) && (j <= plen);
                if (disturb && k == 2) begin
                    load = ((j % 2) == 0);
                    din  = 8'h3C;
                end else begin
                    load = 1'b0;
                end
                @(negedge clk);
            end
        end
        pause = 1'b0;
        load  = 1'b0;
        check_eq({tag, " done"},  {31'd0, o_done},  32'd1);
        check_eq({tag, " dbusy"}, {31'd0, o_busy},  32'd1);
        check_eq({tag, " drdy"},  {31'd0, o_ready}, 32'd0);
        check_eq({tag, " dval"},  {31'd0, o_valid}, 32'd0);
        check_eq({tag, " dsout"}, {31'd0, o_sout},  32'd0);
        @(negedge clk);
        check_eq({tag, " ready"}, {31'd0, o_ready}, 32'd1);
        check_eq({tag, " idone"}, {31'd0, o_done},  32'd0);
        check_eq({tag, " ibusy"}, {31'd0, o_busy},  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        logic ev, es, ed, er;
        n_total = 0;
        n_bad   = 0;
        sel     = 0;
        rst     = 1'b1;
        load    = 1'b0;
        din     = 8'h00;
        pause   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check_eq("rst ready", {31'd0, o_ready}, 32'd1);
        check_eq("rst busy",  {31'd0, o_busy},  32'd0);
        check_eq("rst sout",  {31'd0, o_sout},  32'd0);
        check_eq("rst valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst done",  {31'd0, o_done},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic word, LSB first.
        sel = 0;
        send_word("lsb_a5", 8'hA5, 4, 1'b1, -1, 0, 1'b0);

        // MSB first.
        pulse_reset();
        sel = 1;
        send_word("msb_a5", 8'hA5, 4, 1'b0, -1, 0, 1'b0);
        send_word("msb_01", 8'h01, 4, 1'b0, -1, 0, 1'b0);

        // Ignored load/din while busy, then no further words.
        pulse_reset();
        sel = 0;
        send_word("ign_c3", 8'hC3, 4, 1'b1, -1, 0, 1'b1);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid || o_done) dcnt++;
            @(negedge clk);
        end
        check_eq("ign extra", dcnt, 32'd0);

        // Pause for 5 cycles during bit 3.
        pulse_reset();
        sel = 0;
        send_word("pause_96", 8'h96, 4, 1'b1, 3, 5, 1'b0);

        // C=1 with load held high: FF then 00.
        pulse_reset();
        sel  = 2;
        din  = 8'hFF;
        load = 1'b1;
        @(negedge clk);
        din  = 8'h00;
        dcnt = 0;
        for (int i = 0; i < 24; i++) begin
            ev = (i <= 7) || (i >= 10 && i <= 17);
            es = (i <= 7);
            ed = (i == 8) || (i == 18);
            er = (i == 9) || (i >= 19);
            check_eq($sformatf("c1 i%0d valid", i), {31'd0, o_valid}, {31'd0, ev});
            check_eq($sformatf("c1 i%0d sout", i),  {31'd0, o_sout},  {31'd0, es});
            check_eq($sformatf("c1 i%0d done", i),  {31'd0, o_done},  {31'd0, ed});
            check_eq($sformatf("c1 i%0d ready", i), {31'd0, o_ready}, {31'd0, er});
            if (o_done) dcnt++;
            if (i == 10) load = 1'b0;
            @(negedge clk);
        end
        check_eq("c1 done pulses", dcnt, 32'd2);

        // Reset during bit 4.
        pulse_reset();
        sel  = 0;
        din  = 8'hFF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("mid valid", {31'd0, o_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid ready", {31'd0, o_ready}, 32'd1);
        check_eq("mid sout",  {31'd0, o_sout},  32'd0);
        check_eq("mid valid0", {31'd0, o_valid}, 32'd0);
        check_eq("mid busy",  {31'd0, o_busy},  32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) dcnt++;
            @(negedge clk);
        end
        check_eq("mid no done", dcnt, 32'd0);
        send_word("post_5a", 8'h5A, 4, 1'b1, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
